// File: rtl/core_alu_wide.sv
// Slice-serial wide ALU: runs the 16 core ALU ops on WIDTH-bit operands, SLICE bits per clock,
// carrying the carry/shift bit between slices in a single register.
module core_alu_wide #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [3:0]       I_op,
  input  logic [WIDTH-1:0] I_lhs,
  input  logic [WIDTH-1:0] I_rhs,
  input  logic [3:0]       I_flags,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [WIDTH-1:0] O_result,
  output logic [3:0]       O_flags
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADC = 4'd1,  OP_SBC = 4'd2,  OP_INC = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4,  OP_CMP = 4'd5,  OP_BIT = 4'd6,  OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8,  OP_XOR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11;
  localparam logic [3:0] OP_ASL = 4'd12, OP_LSR = 4'd13, OP_TXR = 4'd14, OP_TXL = 4'd15;

  if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("core_alu_wide: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [3:0]       op_q, fin_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic             carry_q, z_q, n_q;

  logic             accept, first, last, msb_first, cin;
  int               idx, sh;
  logic [SLICE-1:0] a_s, b_s, bx, r_s, fv_s;
  logic [SLICE:0]   sum;
  logic             cout, z_now, n_now, v_now;
  logic [3:0]       fin_flags;

  assign O_ready  = (state_q == S_IDLE) && !I_reset;
  assign O_valid  = (state_q == S_DONE);
  assign O_result = result_q;
  assign O_flags  = flags_q;
  assign accept   = I_valid && O_ready;

  always_comb begin
    first     = (cnt_q == '0);
    last      = (cnt_q == CW'(NSLICE - 1));
    msb_first = (op_q == OP_ROR) || (op_q == OP_LSR);
    idx       = msb_first ? (NSLICE - 1 - int'(cnt_q)) : int'(cnt_q);
    sh        = idx * SLICE;
    a_s       = SLICE'(a_q >> sh);
    b_s       = SLICE'(b_q >> sh);

    // Carry seed for the first slice; afterwards the chained carry/shift bit is used.
    cin = carry_q;
    if (first) begin
      case (op_q)
        OP_ADC, OP_SBC, OP_ROL, OP_ROR: cin = fin_q[0];
        OP_INC, OP_CMP:                 cin = 1'b1;
        default:                        cin = 1'b0;
      endcase
    end

    case (op_q)
      OP_ADC:         bx = b_s;
      OP_SBC, OP_CMP: bx = ~b_s;
      OP_DEC:         bx = '1;
      default:        bx = '0;
    endcase
    sum = {1'b0, a_s} + {1'b0, bx} + {{SLICE{1'b0}}, cin};

    r_s  = a_s;
    fv_s = a_s;
    cout = cin;
    case (op_q)
      OP_ADC, OP_SBC, OP_INC, OP_DEC: begin
        r_s = sum[SLICE-1:0]; fv_s = sum[SLICE-1:0]; cout = sum[SLICE];
      end
      OP_CMP: begin
        fv_s = sum[SLICE-1:0]; cout = sum[SLICE];
      end
      OP_BIT: fv_s = a_s & b_s;
      OP_AND: begin r_s = a_s & b_s; fv_s = a_s & b_s; end
      OP_OR:  begin r_s = a_s | b_s; fv_s = a_s | b_s; end
      OP_XOR: begin r_s = a_s ^ b_s; fv_s = a_s ^ b_s; end
      OP_ROL, OP_ASL: begin
        {cout, r_s} = {a_s, cin}; fv_s = r_s;
      end
      OP_ROR, OP_LSR: begin
        {r_s, cout} = {cin, a_s}; fv_s = r_s;
      end
      OP_TXR, OP_TXL: begin r_s = b_s; fv_s = b_s; end
      default: ;
    endcase

    z_now = (first ? 1'b1 : z_q) & (fv_s == '0);
    n_now = (idx == NSLICE - 1) ? fv_s[SLICE-1] : n_q;
    v_now = (a_s[SLICE-1] == bx[SLICE-1]) && (sum[SLICE-1] != a_s[SLICE-1]);
    acc_d = (first ? '0 : acc_q) | (WIDTH'(r_s) << sh);

    case (op_q)
      OP_ADC, OP_SBC:
        fin_flags = {n_now, v_now, z_now, cout};
      OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_TXR:
        fin_flags = {n_now, fin_q[2], z_now, fin_q[0]};
      OP_CMP, OP_ROL, OP_ROR, OP_ASL, OP_LSR:
        fin_flags = {n_now, fin_q[2], z_now, cout};
      OP_BIT:
        fin_flags = {b_q[WIDTH-1], b_q[WIDTH-2], z_now, fin_q[0]};
      default:
        fin_flags = fin_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: if (last) begin
        state_d  = S_DONE;
        cnt_d    = '0;
        result_d = acc_d;
        flags_d  = fin_flags;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_DONE: if (I_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Operand latches and slice accumulators carry no reset: every op reseeds them.
  always_ff @(posedge I_clk) begin
    if (accept) begin
      op_q  <= I_op;
      a_q   <= I_lhs;
      b_q   <= I_rhs;
      fin_q <= I_flags;
    end
    if (state_q == S_EXEC) begin
      carry_q <= cout;
      z_q     <= z_now;
      n_q     <= n_now;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_core_alu_wide.sv
// Bench for core_alu_wide: a 16/8 and a 32/8 instance checked against a whole-word reference model.
module tb_core_alu_wide;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v16, rdy16, ov16, ir16;
  logic [3:0]  op16, f16i, f16o;
  logic [15:0] a16, b16, r16;
  logic        v32, rdy32, ov32, ir32;
  logic [3:0]  op32, f32i, f32o;
  logic [31:0] a32, b32, r32;

  int n_cmp = 0;
  int n_bad = 0;

  core_alu_wide #(.WIDTH(16), .SLICE(8)) dut16 (
    .I_clk(clk), .I_reset(rst), .I_valid(v16), .O_ready(rdy16), .I_op(op16),
    .I_lhs(a16), .I_rhs(b16), .I_flags(f16i), .O_valid(ov16), .I_ready(ir16),
    .O_result(r16), .O_flags(f16o)
  );

  core_alu_wide #(.WIDTH(32), .SLICE(8)) dut32 (
    .I_clk(clk), .I_reset(rst), .I_valid(v32), .O_ready(rdy32), .I_op(op32),
    .I_lhs(a32), .I_rhs(b32), .I_flags(f32i), .O_valid(ov32), .I_ready(ir32),
    .O_result(r32), .O_flags(f32o)
  );

  // Whole-word reference: returns {N,V,Z,C, R} for a w-bit ALU.
  function automatic logic [67:0] ref_alu(input int w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] f);
    logic [63:0] m, r, nb;
    logic [64:0] s;
    logic n, v, z, c, upd;
    m  = (64'd1 << w) - 64'd1;
    nb = ~b & m;
    r = a; n = f[3]; v = f[2]; z = f[1]; c = f[0]; upd = 1'b1;
    case (op)
      4'd0: upd = 1'b0;
      4'd1, 4'd2: begin
        s = {1'b0, a} + {1'b0, (op == 4'd1) ? b : nb} + 65'(f[0]);
        r = s[63:0] & m;
        c = s[w];
        v = (a[w-1] == ((op == 4'd1) ? b[w-1] : nb[w-1])) && (r[w-1] != a[w-1]);
      end
      4'd3: r = (a + 64'd1) & m;
      4'd4: r = (a - 64'd1) & m;
      4'd5: begin
        s = {1'b0, a} + {1'b0, nb} + 65'd1;
        c = s[w]; n = s[w-1]; z = ((s[63:0] & m) == 64'd0); upd = 1'b0;
      end
      4'd6: begin
        z = ((a & b) == 64'd0); n = b[w-1]; v = b[w-2]; upd = 1'b0;
      end
      4'd7:  r = a & b;
      4'd8:  r = a | b;
      4'd9:  r = a ^ b;
      4'd10: begin r = ((a << 1) | 64'(f[0])) & m; c = a[w-1]; end
      4'd11: begin r = (a >> 1) | (64'(f[0]) << (w - 1)); c = a[0]; end
      4'd12: begin r = (a << 1) & m; c = a[w-1]; end
      4'd13: begin r = a >> 1; c = a[0]; end
      4'd14: r = b;
      default: begin r = b; upd = 1'b0; end
    endcase
    if (upd) begin
      n = r[w-1];
      z = (r == 64'd0);
    end
    return {n, v, z, c, r};
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return m >> 1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Presents one request, then waits (bounded) for O_valid; lat = edges from accept, -1 on timeout.
  task automatic start_op(input bit wide, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] f,
                          output logic [63:0] r, output logic [3:0] fl, output int lat);
    int k;
    lat = -1; r = '0; fl = '0;
    @(negedge clk);
    k = 0;
    while (!(wide ? rdy32 : rdy16) && k < 20) begin @(negedge clk); k++; end
    if (wide) begin v32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; f32i = f; end
    else      begin v16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; f16i = f; end
    @(posedge clk); #1;
    v16 = 1'b0; v32 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); f16i = 4'($urandom);
    a32 = $urandom; b32 = $urandom; f32i = 4'($urandom); op16 = 4'($urandom); op32 = 4'($urandom);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (wide ? ov32 : ov16) begin lat = i; break; end
    end
    if (lat > 0) begin
      r  = wide ? {32'd0, r32} : {48'd0, r16};
      fl = wide ? f32o : f16o;
    end
  endtask

  task automatic finish_op(input bit wide);
    @(negedge clk);
    if (wide) ir32 = 1'b1; else ir16 = 1'b1;
    @(posedge clk); #1;
    ir16 = 1'b0; ir32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ov16 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ov16); end
    n_cmp++; if (rdy16 !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", rdy16); end
    n_cmp++; if (r16 !== 16'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0000", r16); end
    n_cmp++; if (f16o !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", f16o); end
    n_cmp++; if (rdy32 !== 1'b0 || ov32 !== 1'b0) begin n_bad++; $display("FAIL reset_32: got rdy=%b vld=%b want 0 0", rdy32, ov32); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (rdy16 !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", rdy16); end
  endtask

  task automatic test_directed();
    logic [3:0]  ops [6] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd11, 4'd13};
    logic [15:0] as  [6] = '{16'h7FFF, 16'h0000, 16'h1234, 16'h00FF, 16'h0001, 16'h0001};
    logic [15:0] bs  [6] = '{16'h0001, 16'h0001, 16'h1234, 16'hC000, 16'h0000, 16'h0000};
    logic [3:0]  fs  [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    logic [15:0] er  [6] = '{16'h8000, 16'hFFFF, 16'h1234, 16'h00FF, 16'h8000, 16'h0000};
    logic [3:0]  ef  [6] = '{4'b1100, 4'b1000, 4'b0011, 4'b1110, 4'b1001, 4'b0011};
    logic [63:0] r; logic [3:0] fl; int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(1'b0, ops[i], {48'd0, as[i]}, {48'd0, bs[i]}, fs[i], r, fl, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 2", i, lat); end
      n_cmp++; if (r[15:0] !== er[i]) begin n_bad++; $display("FAIL dir%0d_result: got %h want %h", i, r[15:0], er[i]); end
      n_cmp++; if (fl !== ef[i]) begin n_bad++; $display("FAIL dir%0d_flags: got %b want %b", i, fl, ef[i]); end
      finish_op(1'b0);
    end
  endtask

  task automatic test_random16();
    logic [63:0] a, b, r; logic [3:0] op, f, fl; logic [67:0] exp; int lat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15)); a = pick(16); b = pick(16); f = 4'($urandom);
      exp = ref_alu(16, op, a, b, f);
      start_op(1'b0, op, a, b, f, r, fl, lat);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rnd16_latency op=%0d: got %0d want 2", op, lat); end
      n_cmp++; if (r[15:0] !== exp[15:0]) begin n_bad++; $display("FAIL rnd16_result op=%0d a=%h b=%h f=%b: got %h want %h", op, a[15:0], b[15:0], f, r[15:0], exp[15:0]); end
      n_cmp++; if (fl !== exp[67:64]) begin n_bad++; $display("FAIL rnd16_flags op=%0d a=%h b=%h f=%b: got %b want %b", op, a[15:0], b[15:0], f, fl, exp[67:64]); end
      finish_op(1'b0);
      n_cmp++; if (rdy16 !== 1'b1 || ov16 !== 1'b0) begin n_bad++; $display("FAIL rnd16_return_idle: got rdy=%b vld=%b want 1 0", rdy16, ov16); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, r; logic [3:0] f, fl; logic [67:0] exp; int lat;
    a = 64'h0000_0000_0000_8001; b = 64'h0000_0000_0000_8000; f = 4'b0001;
    exp = ref_alu(16, 4'd1, a, b, f);
    start_op(1'b0, 4'd1, a, b, f, r, fl, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v16 = 1'b1; op16 = 4'd14; a16 = 16'($urandom); b16 = 16'h5A5A; f16i = 4'b1111;
      @(posedge clk); #1;
      n_cmp++; if (ov16 !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held: got %b want 1", ov16); end
      n_cmp++; if (rdy16 !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", rdy16); end
      n_cmp++; if (r16 !== exp[15:0]) begin n_bad++; $display("FAIL bp_result_stable: got %h want %h", r16, exp[15:0]); end
      n_cmp++; if (f16o !== exp[67:64]) begin n_bad++; $display("FAIL bp_flags_stable: got %b want %b", f16o, exp[67:64]); end
    end
    @(negedge clk); v16 = 1'b0;
    finish_op(1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ov16 !== 1'b0 || rdy16 !== 1'b1) begin n_bad++; $display("FAIL bp_no_queued_req: got vld=%b rdy=%b want 0 1", ov16, rdy16); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; logic [3:0] fl; int lat;
    start_op(1'b0, 4'd1, 64'h1234, 64'h0, 4'h0, r, fl, lat);
    finish_op(1'b0);
    @(negedge clk);
    v16 = 1'b1; op16 = 4'd1; a16 = 16'h00FF; b16 = 16'h0F00; f16i = 4'h0;
    @(posedge clk); #1;
    v16 = 1'b0;
    rst = 1'b1; #1;
    n_cmp++; if (ov16 !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", ov16); end
    n_cmp++; if (r16 !== 16'h0) begin n_bad++; $display("FAIL midrst_result: got %h want 0000", r16); end
    n_cmp++; if (f16o !== 4'h0) begin n_bad++; $display("FAIL midrst_flags: got %b want 0000", f16o); end
    n_cmp++; if (rdy16 !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", rdy16); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (ov16 !== 1'b0) begin n_bad++; $display("FAIL midrst_abandoned cycle %0d: got %b want 0", i, ov16); end
    end
    start_op(1'b0, 4'd1, 64'h1, 64'h1, 4'h0, r, fl, lat);
    n_cmp++; if (r[15:0] !== 16'h0002) begin n_bad++; $display("FAIL midrst_next_result: got %h want 0002", r[15:0]); end
    n_cmp++; if (fl !== 4'b0000) begin n_bad++; $display("FAIL midrst_next_flags: got %b want 0000", fl); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL midrst_next_latency: got %0d want 2", lat); end
    finish_op(1'b0);
  endtask

  task automatic test_wide32();
    logic [63:0] a, b, r; logic [3:0] op, f, fl; logic [67:0] exp; int lat;
    start_op(1'b1, 4'd3, 64'hFFFF_FFFF, 64'h0, 4'b0001, r, fl, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL w32_inc_latency: got %0d want 4", lat); end
    n_cmp++; if (r[31:0] !== 32'h0) begin n_bad++; $display("FAIL w32_inc_result: got %h want 00000000", r[31:0]); end
    n_cmp++; if (fl !== 4'b0011) begin n_bad++; $display("FAIL w32_inc_flags: got %b want 0011", fl); end
    finish_op(1'b1);
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15)); a = pick(32); b = pick(32); f = 4'($urandom);
      exp = ref_alu(32, op, a, b, f);
      start_op(1'b1, op, a, b, f, r, fl, lat);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rnd32_latency op=%0d: got %0d want 4", op, lat); end
      n_cmp++; if (r[31:0] !== exp[31:0]) begin n_bad++; $display("FAIL rnd32_result op=%0d a=%h b=%h f=%b: got %h want %h", op, a[31:0], b[31:0], f, r[31:0], exp[31:0]); end
      n_cmp++; if (fl !== exp[67:64]) begin n_bad++; $display("FAIL rnd32_flags op=%0d a=%h b=%h f=%b: got %b want %b", op, a[31:0], b[31:0], f, fl, exp[67:64]); end
      finish_op(1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    v16 = 1'b0; ir16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; f16i = '0;
    v32 = 1'b0; ir32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; f32i = '0;
    test_reset();
    test_directed();
    test_random16();
    test_backpressure();
    test_reset_mid();
    test_wide32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
